// File: rtl/branch_pred_cmp.sv
// branch_pred_cmp: decode-stage branch comparator with a bimodal predictor.
//
// The decode stage resolves conditional branches in the same cycle, which
// lets d_mispredict redirect fetch with zero latency. Resolved branches go
// through one register stage (r_*). The next cycle trains a table of 2-bit
// saturating counters that fetch reads combinationally through f_pc.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   stall, flush        decode hold / squash (flush wins over stall)
//   f_pc, f_pred_taken  fetch lookup and its predicted direction
//   d_valid, d_pc, d_op decode instruction, PC and EXE_*_OP code
//   d_a, d_b            forwarded rs/rt operands, WIDTH bits
//   d_pred_taken        prediction carried down from fetch
//   d_is_branch         d_op is a conditional branch
//   d_taken             branch condition true
//   d_mispredict        resolved direction differs from the prediction
//   stat_branches       resolved-branch count
//   stat_mispredicts    mispredict count
//
// Build option: define BRANCH_STATS_EN to build the saturating statistic
// counters. Without it, both statistic ports are tied to zero.
module branch_pred_cmp #(
  parameter int WIDTH     = 32,
  parameter int BHT_DEPTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic [31:0]      f_pc,
  output logic             f_pred_taken,
  input  logic             d_valid,
  input  logic [31:0]      d_pc,
  input  logic [7:0]       d_op,
  input  logic [WIDTH-1:0] d_a,
  input  logic [WIDTH-1:0] d_b,
  input  logic             d_pred_taken,
  output logic             d_is_branch,
  output logic             d_taken,
  output logic             d_mispredict,
  output logic [31:0]      stat_branches,
  output logic [31:0]      stat_mispredicts
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  localparam logic [7:0] EXE_BLTZ_OP   = 8'b0100_0000;
  localparam logic [7:0] EXE_BGEZ_OP   = 8'b0100_0001;
  localparam logic [7:0] EXE_BLTZAL_OP = 8'b0100_1010;
  localparam logic [7:0] EXE_BGEZAL_OP = 8'b0100_1011;
  localparam logic [7:0] EXE_BEQ_OP    = 8'b0101_0001;
  localparam logic [7:0] EXE_BNE_OP    = 8'b0101_0010;
  localparam logic [7:0] EXE_BLEZ_OP   = 8'b0101_0011;
  localparam logic [7:0] EXE_BGTZ_OP   = 8'b0101_0100;

  // Compare against zero with the sign bit and a zero detect. The most
  // negative value has the sign bit set, so it counts as <0 and <=0.
  logic a_neg, a_zero;
  assign a_neg  = d_a[WIDTH-1];
  assign a_zero = (d_a == '0);

  always_comb begin
    d_is_branch = 1'b0;
    d_taken     = 1'b0;
    case (d_op)
      EXE_BEQ_OP:    begin d_is_branch = 1'b1; d_taken = (d_a == d_b);      end
      EXE_BNE_OP:    begin d_is_branch = 1'b1; d_taken = (d_a != d_b);      end
      EXE_BGTZ_OP:   begin d_is_branch = 1'b1; d_taken = ~a_neg & ~a_zero;  end
      EXE_BLEZ_OP:   begin d_is_branch = 1'b1; d_taken = a_neg | a_zero;    end
      EXE_BLTZ_OP,
      EXE_BLTZAL_OP: begin d_is_branch = 1'b1; d_taken = a_neg;             end
      EXE_BGEZ_OP,
      EXE_BGEZAL_OP: begin d_is_branch = 1'b1; d_taken = ~a_neg;            end
      default:       begin d_is_branch = 1'b0; d_taken = 1'b0;              end
    endcase
  end

  assign d_mispredict = d_valid & d_is_branch & ~flush & (d_taken != d_pred_taken);

  // Resolve stage. A stalled branch is captured only in its first unstalled
  // cycle, so each branch trains the table exactly once.
  logic             r_valid, r_taken, r_mis;
  logic [IDX_W-1:0] r_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_taken <= 1'b0;
      r_mis   <= 1'b0;
      r_idx   <= '0;
    end else begin
      r_valid <= d_valid & d_is_branch & ~stall & ~flush;
      r_taken <= d_taken;
      r_mis   <= (d_taken != d_pred_taken);
      r_idx   <= d_pc[IDX_W+1:2];
    end
  end

  // Table of 2-bit counters. Reset sets every entry to weakly not-taken and
  // drops any pending update. A lookup reads the stored value directly.
  // During an update cycle it returns the old count.
  logic [1:0] bht [BHT_DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= 2'b01;
    end else if (r_valid) begin
      if (r_taken && bht[r_idx] != 2'b11)
        bht[r_idx] <= bht[r_idx] + 2'd1;
      else if (!r_taken && bht[r_idx] != 2'b00)
        bht[r_idx] <= bht[r_idx] - 2'd1;
    end
  end

  assign f_pred_taken = bht[f_pc[IDX_W+1:2]][1];

`ifdef BRANCH_STATS_EN
  logic [31:0] n_br, n_mis;

  always_ff @(posedge clk) begin
    if (rst) begin
      n_br  <= '0;
      n_mis <= '0;
    end else if (r_valid) begin
      if (n_br != 32'hFFFF_FFFF)          n_br  <= n_br + 32'd1;
      if (r_mis && n_mis != 32'hFFFF_FFFF) n_mis <= n_mis + 32'd1;
    end
  end

  assign stat_branches    = n_br;
  assign stat_mispredicts = n_mis;
`else
  assign stat_branches    = '0;
  assign stat_mispredicts = '0;
`endif

  // The table index uses only part of each PC. Without the statistics
  // build, r_mis has no reader.
  logic unused_bits;
  assign unused_bits = ^{f_pc, d_pc, r_mis};

endmodule

// File: doc/branch_pred_cmp.md
BRANCH_PRED_CMP -- requirements
Module: branch_pred_cmp

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits (>=2).
REQ-002 SHALL have parameter BHT_DEPTH, default 64, number of 2-bit predictor entries (power of two, >=2); IDX_W = log2(BHT_DEPTH).
REQ-003 SHALL have ports, clock and reset first:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  decode stage held this cycle.
- flush  in  1  decode-stage instruction squashed this cycle.
- f_pc  in  32  fetch PC for lookup.
- f_pred_taken  out  1  prediction for f_pc.
- d_valid  in  1  decode instruction valid.
- d_pc  in  32  decode PC.
- d_op  in  8  decode op code (EXE_*_OP encodings of defines.vh).
- d_a, d_b  in  WIDTH  rs/rt operands (already forwarded).
- d_pred_taken  in  1  prediction carried from fetch.
- d_is_branch  out  1  d_op is a conditional branch.
- d_taken  out  1  branch condition true.
- d_mispredict  out  1  resolved direction differs from d_pred_taken.
- stat_branches  out  32  resolved-branch count.
- stat_mispredicts  out  32  mispredict count.

Function
REQ-004 SHALL decode d_is_branch=1 for EXE_BEQ_OP, BNE, BGTZ, BLEZ, BLTZ, BLTZAL, BGEZ, BGEZAL; 0 otherwise.
REQ-005 SHALL compute d_taken combinationally, two's-complement over WIDTH bits: BEQ a==b; BNE a!=b; BGTZ a>0; BLEZ a<=0; BLTZ/BLTZAL a<0; BGEZ/BGEZAL a>=0; non-branch 0.
REQ-006 SHALL treat the most-negative value (1 followed by zeros) as <0 and <=0, never >0 or >=0.
REQ-007 SHALL drive d_mispredict = d_valid & d_is_branch & ~flush & (d_taken != d_pred_taken), combinationally, zero latency.
REQ-008 SHALL index the BHT with pc[IDX_W+1:2]; f_pred_taken = MSB of entry at f_pc index, combinational.
REQ-009 SHALL register a resolve stage each cycle: r_valid <= d_valid & d_is_branch & ~stall & ~flush; r_idx, r_taken, r_mis captured alongside.
REQ-010 SHALL, when r_valid=1, update entry r_idx as 2-bit saturating counter: taken increments (max 3), not-taken decrements (min 0); exactly one update per branch.
REQ-011 SHALL, on simultaneous lookup and update of the same index, return the pre-update value on f_pred_taken (no bypass); new value visible the following cycle.
REQ-012 SHALL, when stall=1 with a branch in decode, perform no capture that cycle; capture occurs in the first cycle stall=0.
REQ-013 SHALL give flush priority over stall: flushed instruction never updates BHT or statistics.
REQ-014 SHALL ignore d_pc, d_a, d_b when d_valid=0.

Reset
REQ-015 SHALL, when rst=1 at a clock edge, set every BHT entry to 2'b01 (weakly not-taken), r_valid to 0, both statistics counters to 0.
REQ-016 SHALL suppress any pending update in the reset cycle; a branch in r stage during reset is discarded.
REQ-017 SHALL output f_pred_taken=0 for all PCs in the cycle after reset.

Configuration
REQ-018 SHALL, with macro BRANCH_STATS_EN defined, increment stat_branches on each r_valid cycle and stat_mispredicts on each r_valid & r_mis cycle, both saturating at 32'hFFFF_FFFF.
REQ-019 SHALL, without BRANCH_STATS_EN, keep both statistic ports present and tied to 0, with no counter registers synthesised.

Verification
REQ-020 SHALL cover: d_op=BEQ, a=b=32'h1234 -> d_taken=1; with d_pred_taken=0 -> d_mispredict=1; b=32'h1235 -> d_taken=0.
REQ-021 SHALL cover: BGTZ/BGEZ/BLTZ/BLEZ with a=32'h8000_0000 -> 0,0,1,1; with a=0 -> 0,1,0,1; with a=1 -> 1,1,0,0.
REQ-022 SHALL cover: after reset, same BNE taken at pc 32'h0040_0010 three times -> f_pred_taken for that pc 0 before, 1 after first update, counter saturates at 3; two not-taken -> f_pred_taken 0.
REQ-023 SHALL cover: branch held 3 cycles by stall then released -> exactly one BHT update and stat_branches +1; same branch with flush=1 -> no update, no count.
REQ-024 SHALL cover: lookup at same index as update cycle -> old prediction returned, new one next cycle; rst asserted while r_valid=1 -> entry reads 2'b01, stats 0.
REQ-025 SHALL cover: WIDTH=16, BHT_DEPTH=4 build -> BLTZ with a=16'h8000 taken; pcs 32'h0 and 32'h10 alias to the same entry.
